// File: rtl/fsa_leaf_node_n.sv
// Leaf node of a fair-share arbitration tree: picks one local requester by
// rotating priority, asks the parent for the bus, and holds the grant until release.
module fsa_leaf_node_n #(
  parameter int N        = 4,
  parameter int IDX_W    = $clog2(N),
  parameter int INIT_PTR = 0,
  parameter bit FAIR_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             up_req,
  input  logic             ack,
  input  logic             update,
  output logic             busy,
  output logic             locked
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] ptr_next_s;
  logic             lock_r;
  logic             lock_next_s;
  logic [N-1:0]     grant_next_s;
  logic [IDX_W-1:0] grant_idx_next_s;
  logic             busy_next_s;
  logic             win_found_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             low_req_s;
  logic             capture_s;
  logic             lock_set_s;

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v      = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Winner search: walk from (ptr-1) downward with wrap, first requester wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IDX_W{1'b0}};
    for (int k = 1; k <= N; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(ptr_r) + N - k) % N);
      if (!win_found_s && req[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Sweep-end detection: any requester with an index below the winner.
  always_comb begin
    low_req_s = 1'b0;
    for (int j = 0; j < N; j++) begin
      if ((j < int'(win_idx_s)) && req[j]) begin
        low_req_s = 1'b1;
      end else begin
        low_req_s = low_req_s;
      end
    end
  end

  assign up_req     = (state_r == IDLE) & ~lock_r & (|req);
  assign capture_s  = up_req & ack & win_found_s;
  assign lock_set_s = capture_s & FAIR_EN & ~low_req_s;
  assign locked     = lock_r;

  // Next-state and next-output decode; ack outside a live up_req falls through to hold.
  always_comb begin
    state_next_s     = state_r;
    ptr_next_s       = ptr_r;
    grant_next_s     = grant;
    grant_idx_next_s = grant_idx;
    busy_next_s      = busy;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          state_next_s     = BUSY;
          ptr_next_s       = win_idx_s;
          grant_next_s     = onehot(win_idx_s);
          grant_idx_next_s = win_idx_s;
          busy_next_s      = 1'b1;
        end else begin
          grant_next_s = {N{1'b0}};
          busy_next_s  = 1'b0;
        end
      end
      BUSY: begin
        if (!req[grant_idx]) begin
          state_next_s = IDLE;
          grant_next_s = {N{1'b0}};
          busy_next_s  = 1'b0;
        end else begin
          state_next_s = BUSY;
        end
      end
      default: begin
        state_next_s = IDLE;
        grant_next_s = {N{1'b0}};
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // Lock: root update wins over a same-cycle sweep end.
  always_comb begin
    if (update) begin
      lock_next_s = 1'b0;
    end else if (lock_set_s) begin
      lock_next_s = 1'b1;
    end else begin
      lock_next_s = lock_r;
    end
  end

  // State, pointer, lock and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      ptr_r     <= IDX_W'(INIT_PTR);
      lock_r    <= 1'b0;
      grant     <= {N{1'b0}};
      grant_idx <= {IDX_W{1'b0}};
      busy      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      ptr_r     <= ptr_next_s;
      lock_r    <= lock_next_s;
      grant     <= grant_next_s;
      grant_idx <= grant_idx_next_s;
      busy      <= busy_next_s;
    end
  end

endmodule

// File: tb/tb_fsa_leaf_node_n.sv
// Bench for fsa_leaf_node_n (N=4): directed scenarios plus random traffic,
// checked against a transfer-level model of the leaf.
module tb_fsa_leaf_node_n;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         up_req;
  logic         ack;
  logic         update;
  logic         busy;
  logic         locked;

  int checks;
  int failures;

  // model state: who holds the bus, rotation point, round lock
  bit m_busy;
  int m_gidx;
  int m_ptr;
  bit m_lock;

  fsa_leaf_node_n #(.N(N), .INIT_PTR(0), .FAIR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .grant_idx(grant_idx),
    .up_req(up_req), .ack(ack), .update(update), .busy(busy), .locked(locked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_up_req(input logic [N-1:0] r);
    return !m_busy && !m_lock && (r != 4'b0000);
  endfunction

  // Priority list: ptr-1, ptr-2, ... wrapping, ptr last.
  function automatic int model_winner(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (m_ptr - k + N) % N;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_gidx = 0;
    m_ptr  = 0;
    m_lock = 1'b0;
  endtask

  task automatic model_advance(input logic [N-1:0] r, input logic a, input logic u);
    bit set_lock;
    set_lock = 1'b0;
    if (!m_busy) begin
      if (model_up_req(r) && a) begin
        int w;
        w      = model_winner(r);
        m_busy = 1'b1;
        m_gidx = w;
        m_ptr  = w;
        set_lock = ((int'(r) % (1 << w)) == 0);
      end
    end else if (!r[m_gidx]) begin
      m_busy = 1'b0;
    end
    if (u) m_lock = 1'b0;
    else if (set_lock) m_lock = 1'b1;
  endtask

  task automatic check_outputs();
    logic [N-1:0] g;
    g = m_busy ? (4'b0001 << m_gidx) : 4'b0000;
    check("grant", grant, g);
    check("busy", busy, m_busy);
    check("locked", locked, m_lock);
    if (m_busy) check("grant_idx", grant_idx, m_gidx);
  endtask

  task automatic step(input logic [N-1:0] r, input logic a, input logic u);
    @(negedge clk);
    req = r; ack = a; update = u;
    #1;
    check("up_req", up_req, model_up_req(r));
    model_advance(r, a, u);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; req = 4'b0000; ack = 1'b0; update = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 4'b0000);
    check("rst_idx", grant_idx, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_up_req", up_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // full sweep 3,2,1,0 then lock
    step(4'b1111, 1'b1, 1'b0);
    check("sweep_first", grant, 4'b1000);
    step(4'b0111, 1'b0, 1'b0);
    step(4'b0111, 1'b1, 1'b0);
    check("sweep_second", grant, 4'b0100);
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    check("sweep_third", grant, 4'b0010);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    check("sweep_last", grant, 4'b0001);
    check("sweep_lock", locked, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1110, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    check("locked_no_grant", busy, 1'b0);
    step(4'b1111, 1'b0, 1'b1);
    check("update_unlock", locked, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // lone middle requester ends the sweep; ack while busy ignored
    step(4'b0100, 1'b1, 1'b0);
    check("lone_grant", grant, 4'b0100);
    check("lone_lock", locked, 1'b1);
    step(4'b0100, 1'b1, 1'b0);
    check("ack_busy_ignored", grant, 4'b0100);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);

    // update coinciding with a sweep-end capture
    step(4'b0010, 1'b1, 1'b1);
    check("upd_same_grant", grant, 4'b0010);
    check("upd_same_lock", locked, 1'b0);

    // asynchronous reset mid-transfer
    @(negedge clk);
    req = 4'b0010; ack = 1'b0; update = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_grant", grant, 4'b0000);
    check("async_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111, 1'b1, 1'b0);
    check("post_rst_grant", grant, 4'b1000);
    step(4'b0000, 1'b0, 1'b0);

    // random traffic; the granted requester usually keeps its line up
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      logic a;
      logic u;
      r = N'($urandom_range(0, 15));
      if (m_busy && ($urandom_range(0, 3) != 0)) r[m_gidx] = 1'b1;
      a = 1'($urandom_range(0, 1));
      u = ($urandom_range(0, 9) == 0);
      step(r, a, u);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsa_leaf_node_n.md
FSA_LEAF_NODE_N -- requirements
Module: fsa_leaf_node_n

Interface
REQ-001 Parameter N, default 4: number of local request ports; legal range 2..64.
REQ-002 Parameter IDX_W, default $clog2(N): width of port index fields.
REQ-003 Parameter INIT_PTR, default 0: pointer index loaded at reset; legal range 0..N-1.
REQ-004 Parameter FAIR_EN, default 1: 1 = round-lock fairness enabled; 0 = plain round-robin, lock never set.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  N  active-high local requests; bit i is port i; a requester holds req high for the whole transfer.
REQ-008 grant  output  N  registered one-hot grant, held for the duration of a transfer.
REQ-009 grant_idx  output  IDX_W  binary index of the granted port; valid only while busy=1.
REQ-010 up_req  output  1  request to parent node.
REQ-011 ack  input  1  parent acceptance, 1-cycle pulse; meaningful only when up_req=1.
REQ-012 update  input  1  global round-restart pulse from root.
REQ-013 busy  output  1  high while a local transfer is granted.
REQ-014 locked  output  1  current lock flag; high = leaf has completed its sweep for this round.

Function
REQ-015 State machine: IDLE and BUSY; reset state IDLE.
REQ-016 Priority order: highest = (ptr-1) mod N, descending with wrap-around, lowest = ptr; ptr=0 gives N-1, N-2, ..., 0.
REQ-017 Winner: combinational, highest-priority port with req high in the current cycle.
REQ-018 up_req = (state==IDLE) & ~lock & |req, combinational from registered state plus req.
REQ-019 In IDLE, ack=1 with up_req=1 in cycle t: winner captured; grant=onehot(winner), grant_idx=winner, busy=1 from cycle t+1; state->BUSY.
REQ-020 Capture in cycle t also sets ptr <= winner at t+1.
REQ-021 ack with up_req=0 (IDLE with no req, lock=1, or BUSY) SHALL be ignored: no state, ptr, grant or lock change.
REQ-022 In BUSY, grant, grant_idx and ptr hold; up_req=0; changes on other req bits are ignored.
REQ-023 In BUSY, req[grant_idx]=0 in cycle t: grant=0, busy=0, state->IDLE at t+1; new arbitration earliest in t+1.
REQ-024 Grant latency: exactly 1 cycle after ack; release latency: exactly 1 cycle after granted req drops.
REQ-025 lock_set = capture & FAIR_EN & no req[j] high for any j < winner (sweep end); winner=0 always sets it.
REQ-026 lock priority: update=1 clears lock (overrides a same-cycle lock_set); else lock_set sets lock; else hold.
REQ-027 update has no effect on state, ptr or grant; an in-flight BUSY transfer completes normally.
REQ-028 FAIR_EN=0: lock and locked SHALL remain 0 permanently.
REQ-029 grant is at most one-hot in every cycle; grant=0 whenever busy=0.
REQ-030 INIT_PTR or N outside its legal range is a static configuration error; behaviour is undefined.

Reset
REQ-031 rst_n=0 asynchronously forces state=IDLE, ptr=INIT_PTR, lock=0, grant=0, grant_idx=0, busy=0; up_req then follows REQ-018.
REQ-032 Reset asserted mid-transfer SHALL drop grant immediately without a clock edge; after release, first arbitration uses ptr=INIT_PTR.

Verification (N=4, INIT_PTR=0, FAIR_EN=1)
REQ-033 req=1111, ack pulse -> next cycle grant=1000, grant_idx=3, busy=1, up_req=0, locked=0.
REQ-034 Continue: drop req[3], hold 0111 -> next cycle grant=0, busy=0, up_req=1; each following ack+drop grants 0100, 0010, 0001 in order.
REQ-035 After grant of port 0 -> locked=1, up_req=0 while req=1111; update pulse -> next cycle locked=0, up_req=1.
REQ-036 req=0100 only, ack -> grant=0100 and locked=1 (no lower requester); ack while busy -> ignored, grant unchanged.
REQ-037 update and sweep-end capture in the same cycle -> locked=0 next cycle, grant still issued.
REQ-038 rst_n low during BUSY with grant=0010 -> grant=0, busy=0 with no clock edge; after release, req=1111+ack grants 1000.
